// File: rtl/sdram_line_reader.sv
// sdram_line_reader: single 4 x 16-bit line buffer serving client word reads from SDRAM controller bursts
module sdram_line_reader #(
  parameter int ACK_WAIT   = 6,
  parameter int RD_LOW_MIN = 2
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        cl_rd,
  input  logic [23:0] cl_addr,
  input  logic        cl_inval,
  output logic [15:0] cl_data,
  output logic        cl_valid,
  output logic        cl_busy,
  output logic [24:0] sd_addr,
  output logic        sd_rd,
  output logic        sd_we,
  input  logic [63:0] sd_dout,
  input  logic        sd_ready_first,
  input  logic        sd_ready_fourth
);
  localparam int AW = $clog2(ACK_WAIT + 1);
  localparam int LW = $clog2(RD_LOW_MIN + 1);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_WAIT - 1);
  localparam logic [LW-1:0] LOW_SAT = LW'(RD_LOW_MIN);
  typedef enum logic [2:0] {IDLE, RD_GAP, ISSUE, WAIT_ACK, WAIT_DATA, FILL} state_t;
  state_t state;
  logic line_valid, fwd_done, inval_pend, hit;
  logic [21:0] tag;
  logic [1:0] idx;
  logic [63:0] line;
  logic [AW-1:0] ack_cnt;
  logic [LW-1:0] low_cnt;
  function automatic logic [15:0] word_of(input logic [63:0] l, input logic [1:0] k);
    logic [63:0] s;
    s = l >> {~k, 4'd0};
    return s[15:0];
  endfunction
  assign sd_we = 1'b0;
  assign hit = line_valid && !cl_inval && (cl_addr[23:2] == tag);
  always_ff @(posedge clk or negedge nRESET)
    if (!nRESET) begin
      state      <= IDLE;
      line_valid <= 1'b0;
      fwd_done   <= 1'b0;
      inval_pend <= 1'b0;
      tag        <= '0;
      idx        <= '0;
      line       <= '0;
      cl_data    <= '0;
      cl_valid   <= 1'b0;
      cl_busy    <= 1'b0;
      sd_rd      <= 1'b0;
      sd_addr    <= '0;
      ack_cnt    <= '0;
      low_cnt    <= LOW_SAT;
    end else begin
      cl_valid <= 1'b0;
      low_cnt  <= sd_rd ? '0 : (low_cnt == LOW_SAT ? low_cnt : low_cnt + 1'b1);
      if (cl_busy && cl_inval) inval_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (cl_inval) line_valid <= 1'b0;
          if (cl_rd && hit) begin
            cl_data  <= word_of(line, cl_addr[1:0]);
            cl_valid <= 1'b1;
          end else if (cl_rd) begin
            tag        <= cl_addr[23:2];
            idx        <= cl_addr[1:0];
            cl_busy    <= 1'b1;
            fwd_done   <= 1'b0;
            inval_pend <= 1'b0;
            state      <= RD_GAP;
          end
        end
        // the controller only reacts to a rising edge, so sd_rd must sit low long enough first
        RD_GAP: if (low_cnt == LOW_SAT) state <= ISSUE;
        ISSUE: begin
          sd_addr <= {tag, 3'b000};
          sd_rd   <= 1'b1;
          ack_cnt <= '0;
          state   <= WAIT_ACK;
        end
        // ready_fourth that never drops means the controller reused its last burst for this address
        WAIT_ACK:
          if (!sd_ready_fourth) state <= WAIT_DATA;
          else if (ack_cnt == ACK_LAST) state <= FILL;
          else ack_cnt <= ack_cnt + 1'b1;
        WAIT_DATA: begin
          if (sd_ready_first && idx == 2'd0 && !fwd_done) begin
            cl_data  <= sd_dout[63:48];
            cl_valid <= 1'b1;
            fwd_done <= 1'b1;
          end
          if (sd_ready_fourth) state <= FILL;
        end
        FILL: begin
          line       <= sd_dout;
          line_valid <= ~(inval_pend | cl_inval);
          inval_pend <= 1'b0;
          sd_rd      <= 1'b0;
          cl_busy    <= 1'b0;
          fwd_done   <= 1'b0;
          state      <= IDLE;
          if (!fwd_done) begin
            cl_data  <= word_of(sd_dout, idx);
            cl_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sdram_line_reader.sv
// tb_sdram_line_reader: directed scoreboard bench with a small SDRAM controller ready/data model
module tb_sdram_line_reader;
  logic clk = 1'b0;
  logic nRESET = 1'b0;
  logic cl_rd = 1'b0;
  logic cl_inval = 1'b0;
  logic [23:0] cl_addr = '0;
  logic [15:0] cl_data;
  logic cl_valid, cl_busy, sd_rd, sd_we;
  logic [24:0] sd_addr;
  logic [63:0] sd_dout = '0;
  logic sd_ready_first = 1'b0;
  logic sd_ready_fourth = 1'b0;
  logic [63:0] next_data = '0;
  bit keep = 1'b0;
  logic prev_rd = 1'b0;
  int cyc = 0, cnt = 0, rises = 0, low_run = 0, last_gap = 0, rf_cyc = 0, valid_cyc = -1;
  int n_checks = 0, n_fail = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  sdram_line_reader #(.ACK_WAIT(6), .RD_LOW_MIN(2)) dut (
    .clk(clk), .nRESET(nRESET), .cl_rd(cl_rd), .cl_addr(cl_addr), .cl_inval(cl_inval),
    .cl_data(cl_data), .cl_valid(cl_valid), .cl_busy(cl_busy), .sd_addr(sd_addr),
    .sd_rd(sd_rd), .sd_we(sd_we), .sd_dout(sd_dout), .sd_ready_first(sd_ready_first),
    .sd_ready_fourth(sd_ready_fourth)
  );

  // controller model: on an sd_rd rise drop the ready flags, then 12 cycles later present the burst
  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_rd <= sd_rd;
    if (sd_rd && !prev_rd) begin
      rises <= rises + 1;
      last_gap <= low_run;
      low_run <= 0;
      if (!keep) begin
        sd_ready_first <= 1'b0;
        sd_ready_fourth <= 1'b0;
        cnt <= 12;
      end
    end else begin
      if (!sd_rd) low_run <= low_run + 1;
      if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 3) begin
          sd_ready_first <= 1'b1;
          sd_dout <= next_data;
          rf_cyc <= cyc + 1;
        end
        if (cnt == 1) sd_ready_fourth <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (cl_valid === 1'b1) begin
        valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got cl_valid with cl_data=%h, expected no cl_valid", cl_data);
        end else begin
          e = exp_q.pop_front();
          chk("cl_data", 64'(cl_data), 64'(e));
        end
      end
    end
  endtask

  task automatic do_rd(input logic [23:0] a, input bit push, input logic [15:0] e);
    cl_addr = a;
    cl_rd = 1'b1;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    cl_rd = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((cl_busy !== 1'b0 || exp_q.size() != 0) && n < 200);
    n_checks++;
    if (cl_busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got busy=%b pending=%0d, expected idle with 0 pending", name, cl_busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    fork
      monitor();
      begin
        #400000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1);
      end
    join_none
    repeat (3) @(negedge clk);
    chk("rst_cl_data", 64'(cl_data), 64'h0);
    chk("rst_cl_valid", 64'(cl_valid), 64'h0);
    chk("rst_cl_busy", 64'(cl_busy), 64'h0);
    chk("rst_sd_rd", 64'(sd_rd), 64'h0);
    chk("rst_sd_addr", 64'(sd_addr), 64'h0);
    chk("sd_we", 64'(sd_we), 64'h0);
    nRESET = 1'b1;
    @(negedge clk);
    // cold miss, index 2
    next_data = 64'h1111_2222_3333_4444;
    do_rd(24'h000012, 1'b1, 16'h3333);
    wait_done("cold");
    chk("cold_sd_addr", 64'(sd_addr), 64'h20);
    chk("cold_rises", 64'(rises), 64'd1);
    // hit, latency 1, no SDRAM traffic
    do_rd(24'h000013, 1'b1, 16'h4444);
    chk("hit_latency", 64'(cl_valid), 64'h1);
    chk("hit_busy", 64'(cl_busy), 64'h0);
    chk("hit_sd_rd", 64'(sd_rd), 64'h0);
    wait_done("hit");
    chk("hit_rises", 64'(rises), 64'd1);
    // early forward of word 0
    next_data = 64'h1111_5555_6666_7777;
    do_rd(24'h000100, 1'b1, 16'h1111);
    wait_done("fwd");
    repeat (4) @(negedge clk);
    chk("fwd_timing", 64'(valid_cyc), 64'(rf_cyc + 1));
    chk("fwd_sd_addr", 64'(sd_addr), 64'h200);
    chk("fwd_rises", 64'(rises), 64'd2);
    do_rd(24'h000102, 1'b1, 16'h6666);
    wait_done("fwd_hit");
    chk("fwd_hit_rises", 64'(rises), 64'd2);
    // invalidate then same-address shortcut: controller keeps ready_fourth high
    cl_inval = 1'b1;
    @(negedge clk);
    cl_inval = 1'b0;
    keep = 1'b1;
    do_rd(24'h000100, 1'b1, 16'h1111);
    wait_done("shortcut");
    keep = 1'b0;
    chk("shortcut_rises", 64'(rises), 64'd3);
    do_rd(24'h000101, 1'b1, 16'h5555);
    wait_done("shortcut_hit");
    chk("shortcut_hit_rises", 64'(rises), 64'd3);
    // invalidate during the fill, plus a stray read while busy
    next_data = 64'hdead_beef_cafe_f00d;
    do_rd(24'h000203, 1'b1, 16'hf00d);
    repeat (8) @(negedge clk);
    chk("mid_busy", 64'(cl_busy), 64'h1);
    cl_inval = 1'b1;
    cl_rd = 1'b1;
    cl_addr = 24'h000000;
    @(negedge clk);
    cl_inval = 1'b0;
    cl_rd = 1'b0;
    wait_done("inval_fill");
    chk("inval_fill_rises", 64'(rises), 64'd4);
    do_rd(24'h000202, 1'b1, 16'hcafe);
    wait_done("inval_refetch");
    chk("inval_refetch_rises", 64'(rises), 64'd5);
    chk("rd_low_gap", 64'(last_gap >= 2), 64'h1);
    do_rd(24'h000201, 1'b1, 16'hbeef);
    wait_done("refetch_hit");
    chk("refetch_hit_rises", 64'(rises), 64'd5);
    // async reset in the middle of a burst
    next_data = 64'h0123_4567_89ab_cdef;
    do_rd(24'h000300, 1'b0, 16'h0);
    repeat (8) @(negedge clk);
    chk("pre_rst_busy", 64'(cl_busy), 64'h1);
    #2 nRESET = 1'b0;
    #1;
    chk("async_rst_sd_rd", 64'(sd_rd), 64'h0);
    chk("async_rst_busy", 64'(cl_busy), 64'h0);
    chk("async_rst_valid", 64'(cl_valid), 64'h0);
    chk("async_rst_sd_addr", 64'(sd_addr), 64'h0);
    @(negedge clk);
    nRESET = 1'b1;
    repeat (20) @(negedge clk);
    do_rd(24'h000202, 1'b1, 16'h89ab);
    wait_done("post_rst");
    chk("post_rst_rises", 64'(rises), 64'd7);
    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
